liteeth_sram_tx_reader: RTL and testbench

Streams frames out of the 32-bit dual-port packet SRAM (`liteeth_1rw1r_32w384d_32_sram`) by driving its read-only port (port 1). It accepts a slot/length command, issues word reads, and absorbs the macro's one-cycle registered read latency in a 3-entry skid FIFO. It emits a LiteEth-style valid/ready byte stream with `last`/`last_be`, and pulses a completion so the slot can be freed. The block sits directly downstream of the SRAM macro, between it and the MAC TX path.

---
 rtl/liteeth_sram_tx_reader.sv | 225 ++++++++++++++++++++++
 tb/tb_liteeth_sram_tx_reader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/liteeth_sram_tx_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : liteeth_sram_tx_reader                                          |
// | Reads a frame out of the packet SRAM read port and streams it as 32-bit  |
// | valid/ready beats. Optional counters: LITEETH_SRAM_READER_STATS_EN.      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module liteeth_sram_tx_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int SLOT_WORDS = 192,
  parameter int NSLOTS     = 2,
  parameter int SLOT_WIDTH = 1,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SLOT_WIDTH-1:0] cmd_slot,
  input  logic [LEN_WIDTH-1:0]  cmd_length,
  output logic                  sram_csb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [31:0]           sram_dout,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic [31:0]           src_data,
  output logic                  src_last,
  output logic [3:0]            src_last_be,
  output logic                  done_valid,
  output logic [SLOT_WIDTH-1:0] done_slot,
  output logic                  done_error
`ifdef LITEETH_SRAM_READER_STATS_EN
  ,
  output logic [15:0]           stat_frames,
  output logic [15:0]           stat_errors
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int               c_word_w  = LEN_WIDTH - 1;
  localparam logic [LEN_WIDTH:0] c_max_len = (LEN_WIDTH+1)'(SLOT_WORDS * 4);

  logic [1:0]            r_state;
  logic [SLOT_WIDTH-1:0] r_slot;
  logic [1:0]            r_len_lsb;
  logic [c_word_w-1:0]   r_words;
  logic [c_word_w-1:0]   r_idx;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_done_valid;
  logic                  r_done_error;
  logic [SLOT_WIDTH-1:0] r_done_slot;

  logic [31:0]           r_fifo_data [3];
  logic [2:0]            r_fifo_last;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_count;

  logic                  w_cmd_fire;
  logic [LEN_WIDTH:0]    w_len_plus3;
  logic [c_word_w-1:0]   w_words;
  logic                  w_illegal;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_last;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign cmd_ready   = (r_state == IDLE) && !sys_rst;
  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_len_plus3 = {1'b0, cmd_length} + (LEN_WIDTH+1)'(3);
  assign w_words     = w_len_plus3[LEN_WIDTH:2];
  assign w_illegal   = (cmd_length == '0) ||
                       ({1'b0, cmd_length} > c_max_len) ||
                       (32'(cmd_slot) >= 32'(NSLOTS));

  // Issue depends only on registered occupancy, so src_ready never reaches the SRAM port.
  assign w_issue   = (r_state == READ) &&
                     (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3);
  assign w_rd_addr = r_base + ADDR_WIDTH'(r_idx);
  assign sram_csb  = !w_issue;
  assign sram_addr = w_issue ? w_rd_addr : r_addr_hold;

  assign w_push      = r_inflight;
  assign w_pop       = src_valid && src_ready;
  assign w_head_last = r_fifo_last[r_rd_ptr];

  assign src_valid = (r_count != 2'd0);
  assign src_data  = src_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign src_last  = src_valid && w_head_last;

  always_comb begin
    src_last_be = 4'b0000;
    if (src_last) begin
      case (r_len_lsb)
        2'd0:    src_last_be = 4'b1000;
        2'd1:    src_last_be = 4'b0001;
        2'd2:    src_last_be = 4'b0010;
        default: src_last_be = 4'b0100;
      endcase
    end
  end

  assign done_valid = r_done_valid;
  assign done_error = r_done_error;
  assign done_slot  = r_done_slot;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state         <= IDLE;
      r_slot          <= '0;
      r_len_lsb       <= 2'd0;
      r_words         <= '0;
      r_idx           <= '0;
      r_base          <= '0;
      r_addr_hold     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done_valid    <= 1'b0;
      r_done_error    <= 1'b0;
      r_done_slot     <= '0;
    end else begin
      r_done_valid    <= 1'b0;
      r_done_error    <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_idx == (r_words - c_word_w'(1)));
      if (w_issue) begin
        r_addr_hold <= w_rd_addr;
        r_idx       <= r_idx + c_word_w'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            if (w_illegal) begin
              r_done_valid <= 1'b1;
              r_done_error <= 1'b1;
              r_done_slot  <= cmd_slot;
            end else begin
              r_slot    <= cmd_slot;
              r_len_lsb <= cmd_length[1:0];
              r_words   <= w_words;
              r_idx     <= '0;
              r_base    <= ADDR_WIDTH'(32'(cmd_slot) * SLOT_WORDS);
              r_state   <= READ;
            end
          end
        end
        READ: begin
          if (w_issue && ((r_idx + c_word_w'(1)) == r_words)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last beat can only leave after every read has landed, so its handshake ends the frame.
          if (w_pop && w_head_last) begin
            r_done_valid <= 1'b1;
            r_done_slot  <= r_slot;
          end
          if (r_done_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 2'd0;
      r_fifo_last <= 3'b000;
    end else begin
      if (w_push) begin
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= sram_dout;
    end
  end

`ifdef LITEETH_SRAM_READER_STATS_EN
  logic [15:0] r_stat_frames;
  logic [15:0] r_stat_errors;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stat_frames <= 16'd0;
      r_stat_errors <= 16'd0;
    end else if (r_done_valid) begin
      if (r_done_error) r_stat_errors <= r_stat_errors + 16'd1;
      else              r_stat_frames <= r_stat_frames + 16'd1;
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_errors = r_stat_errors;
`endif

endmodule
`default_nettype wire

// File: tb/tb_liteeth_sram_tx_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_liteeth_sram_tx_reader                                       |
// | Directed bench with a queue-based frame model and an SRAM model.         |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_liteeth_sram_tx_reader;

  localparam int ADDR_WIDTH = 9;
  localparam int SLOT_WORDS = 192;
  localparam int NSLOTS     = 2;
  localparam int SLOT_WIDTH = 2;
  localparam int LEN_WIDTH  = 11;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [SLOT_WIDTH-1:0] cmd_slot;
  logic [LEN_WIDTH-1:0]  cmd_length;
  logic                  sram_csb;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_dout = 32'd0;
  logic                  src_valid;
  logic                  src_ready;
  logic [31:0]           src_data;
  logic                  src_last;
  logic [3:0]            src_last_be;
  logic                  done_valid;
  logic [SLOT_WIDTH-1:0] done_slot;
  logic                  done_error;
`ifdef LITEETH_SRAM_READER_STATS_EN
  logic [15:0]           stat_frames;
  logic [15:0]           stat_errors;
`endif

  liteeth_sram_tx_reader #(
    .ADDR_WIDTH(ADDR_WIDTH), .SLOT_WORDS(SLOT_WORDS), .NSLOTS(NSLOTS),
    .SLOT_WIDTH(SLOT_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_slot(cmd_slot), .cmd_length(cmd_length),
    .sram_csb(sram_csb), .sram_addr(sram_addr), .sram_dout(sram_dout),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_last(src_last), .src_last_be(src_last_be),
    .done_valid(done_valid), .done_slot(done_slot), .done_error(done_error)
`ifdef LITEETH_SRAM_READER_STATS_EN
    , .stat_frames(stat_frames), .stat_errors(stat_errors)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] word_at(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Registered-read SRAM: data for an address issued in cycle N appears in N+1.
  always @(posedge sys_clk) if (!sram_csb) sram_dout <= word_at(int'(sram_addr));

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] be_of(input int len);
    case (len % 4)
      0:       return 4'b1000;
      1:       return 4'b0001;
      2:       return 4'b0010;
      default: return 4'b0100;
    endcase
  endfunction

  // Model state
  logic [31:0] exp_data_q[$];
  logic        exp_last_q[$];
  logic [3:0]  exp_be_q[$];
  int          exp_addr_q[$];
  int          exp_done_cyc = -1;
  int          exp_done_slot = 0;
  bit          exp_done_err = 1'b0;
  int          acc_cyc = 0;
  int          frame_slot = 0;
  int          first_issue_cyc = -1;
  int          first_beat_cyc = -1;
  int          issued = 0;
  int          popped = 0;
  int          beats = 0;
  int          last_addr = -1;
  int          addr_log[$];
  logic [3:0]  last_be_seen = 4'd0;
  bit          done_seen = 1'b0;
  int          done_seen_cyc = -1;
  int          done_seen_slot = -1;
  bit          done_seen_err = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic        prev_last = 1'b0;
  logic [3:0]  prev_be = 4'd0;
  int          good_dones = 0;
  int          err_dones = 0;
  bit          bp_mode = 1'b0;

  // Compare process
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      chk(!src_valid && sram_csb && sram_addr == '0 && !cmd_ready && !done_valid &&
          done_slot == '0 && !done_error && src_data == 32'd0 && !src_last && src_last_be == 4'd0,
          "reset_outputs", {src_valid, sram_csb, cmd_ready, done_valid, done_error, src_last}, 6'b010000);
      prev_stall = 1'b0;
      good_dones = 0;
      err_dones  = 0;
    end else begin
      if (!sram_csb) begin
        if (exp_addr_q.size() == 0) chk(1'b0, "unexpected_read", sram_addr, 0);
        else begin
          int e;
          e = exp_addr_q.pop_front();
          chk(int'(sram_addr) == e, "read_addr", sram_addr, e);
        end
        if (first_issue_cyc < 0) begin
          first_issue_cyc = cyc;
          chk(cyc == acc_cyc + 1, "first_read_latency", cyc - acc_cyc, 1);
        end
        issued++;
        last_addr = int'(sram_addr);
        addr_log.push_back(int'(sram_addr));
        chk(issued - popped <= 3, "outstanding_reads", issued - popped, 3);
      end
      if (src_valid) begin
        if (first_beat_cyc < 0) begin
          first_beat_cyc = cyc;
          chk(cyc == acc_cyc + 3, "first_beat_latency", cyc - acc_cyc, 3);
        end
        if (prev_stall)
          chk(src_data == prev_data && src_last == prev_last && src_last_be == prev_be,
              "stall_hold", src_data, prev_data);
        if (exp_data_q.size() == 0) chk(1'b0, "unexpected_beat", src_data, 0);
        else begin
          chk(src_data == exp_data_q[0], "beat_data", src_data, exp_data_q[0]);
          chk(src_last == exp_last_q[0], "beat_last", src_last, exp_last_q[0]);
          chk(src_last_be == exp_be_q[0], "beat_last_be", src_last_be, exp_be_q[0]);
          if (src_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_last_q.pop_front());
            void'(exp_be_q.pop_front());
            popped++;
            beats++;
            if (src_last) begin
              last_be_seen  = src_last_be;
              exp_done_cyc  = cyc + 1;
              exp_done_slot = frame_slot;
              exp_done_err  = 1'b0;
            end
          end
        end
        prev_stall = !src_ready;
        prev_data  = src_data;
        prev_last  = src_last;
        prev_be    = src_last_be;
      end else begin
        if (prev_stall) chk(1'b0, "valid_dropped_in_stall", 0, 1);
        prev_stall = 1'b0;
      end
      if (done_valid) begin
        chk(cyc == exp_done_cyc, "done_cycle", cyc, exp_done_cyc);
        chk(int'(done_slot) == exp_done_slot, "done_slot", done_slot, exp_done_slot);
        chk(done_error == exp_done_err, "done_error", done_error, exp_done_err);
        chk(cmd_ready == exp_done_err, "ready_during_done", cmd_ready, exp_done_err);
        done_seen      = 1'b1;
        done_seen_cyc  = cyc;
        done_seen_slot = int'(done_slot);
        done_seen_err  = done_error;
        if (done_error) err_dones++;
        else            good_dones++;
        exp_done_cyc = -1;
      end else if (cyc == exp_done_cyc) begin
        chk(1'b0, "done_missing", 0, 1);
        exp_done_cyc = -1;
      end
    end
  end

  // 1,0,0,1 backpressure pattern when enabled
  initial begin
    int phase;
    phase = 0;
    src_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      if (bp_mode) begin
        src_ready = (phase == 0) || (phase == 3);
        phase = (phase + 1) % 4;
      end else begin
        src_ready = 1'b1;
        phase = 0;
      end
    end
  end

  task automatic send(input int slot, input int len);
    bit got;
    got = 1'b0;
    @(posedge sys_clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_slot   = SLOT_WIDTH'(slot);
    cmd_length = LEN_WIDTH'(len);
    for (int n = 0; n < 50; n++) begin
      @(negedge sys_clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk(1'b0, "cmd_accept_timeout", 0, 1);
    else begin
      acc_cyc = cyc;
      first_issue_cyc = -1;
      first_beat_cyc = -1;
      issued = 0;
      popped = 0;
      beats = 0;
      last_addr = -1;
      addr_log.delete();
      done_seen = 1'b0;
      done_seen_cyc = -1;
      if (len == 0 || len > SLOT_WORDS * 4 || slot >= NSLOTS) begin
        exp_done_cyc  = cyc + 1;
        exp_done_slot = slot;
        exp_done_err  = 1'b1;
      end else begin
        int words;
        words = (len + 3) / 4;
        frame_slot = slot;
        for (int w = 0; w < words; w++) begin
          exp_addr_q.push_back(slot * SLOT_WORDS + w);
          exp_data_q.push_back(word_at(slot * SLOT_WORDS + w));
          exp_last_q.push_back(w == words - 1);
          exp_be_q.push_back((w == words - 1) ? be_of(len) : 4'b0000);
        end
      end
    end
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge sys_clk);
      if (done_seen) break;
    end
    if (!done_seen) chk(1'b0, "done_timeout", 0, 1);
    @(negedge sys_clk);
    chk(cmd_ready == 1'b1, "ready_after_done", cmd_ready, 1);
  endtask

  task automatic check_error_cmd(input int slot, input int len);
    send(slot, len);
    wait_done(5);
    chk(done_seen_err == 1'b1, "err_flag", done_seen_err, 1);
    chk(done_seen_cyc - acc_cyc == 1, "err_latency", done_seen_cyc - acc_cyc, 1);
    chk(issued == 0 && beats == 0, "err_no_activity", issued + beats, 0);
  endtask

  initial begin
    sys_rst    = 1'b1;
    cmd_valid  = 1'b0;
    cmd_slot   = '0;
    cmd_length = '0;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk(cmd_ready == 1'b1, "ready_after_reset", cmd_ready, 1);

    // Single frame: slot 1, 10 bytes
    send(1, 10);
    wait_done(50);
    chk(beats == 3, "single_beats", beats, 3);
    chk(addr_log.size() == 3, "single_read_count", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk(addr_log[0] == 192 && addr_log[1] == 193 && addr_log[2] == 194,
          "single_addrs", addr_log[2], 194);
    end
    chk(last_be_seen == 4'b0010, "single_last_be", last_be_seen, 4'b0010);
    chk(done_seen_slot == 1 && !done_seen_err, "single_done_slot", done_seen_slot, 1);

    // Backpressure: 64 bytes with 1,0,0,1 ready pattern
    bp_mode = 1'b1;
    send(0, 64);
    wait_done(300);
    bp_mode = 1'b0;
    chk(beats == 16, "bp_beats", beats, 16);
    chk(exp_data_q.size() == 0, "bp_model_empty", exp_data_q.size(), 0);

    // Illegal commands
    check_error_cmd(0, 0);
    check_error_cmd(0, 769);
    check_error_cmd(2, 8);

    // Length boundaries
    send(0, 4);
    wait_done(20);
    chk(beats == 1, "len4_beats", beats, 1);
    chk(last_be_seen == 4'b1000, "len4_last_be", last_be_seen, 4'b1000);
    send(0, 768);
    wait_done(400);
    chk(beats == 192, "len768_beats", beats, 192);
    chk(last_addr == 191, "len768_last_addr", last_addr, 191);

    // Reset during beat 5 of a 20-beat frame
    send(1, 80);
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if (beats >= 4) break;
    end
    chk(beats == 4, "pre_reset_beats", beats, 4);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    exp_data_q.delete();
    exp_last_q.delete();
    exp_be_q.delete();
    exp_addr_q.delete();
    exp_done_cyc = -1;
    done_seen = 1'b0;
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk(!done_seen, "no_done_after_reset", done_seen, 0);
    send(0, 8);
    wait_done(30);
    chk(beats == 2, "post_reset_beats", beats, 2);

    // Statistics traffic: 3 good frames and 2 errors since the reset
    send(1, 12);
    wait_done(30);
    send(0, 16);
    wait_done(30);
    check_error_cmd(0, 0);
    check_error_cmd(3, 4);
    chk(good_dones == 3 && err_dones == 2, "model_done_counts", good_dones, 3);
`ifdef LITEETH_SRAM_READER_STATS_EN
    chk(stat_frames == 16'd3, "stat_frames", stat_frames, 3);
    chk(stat_errors == 16'd2, "stat_errors", stat_errors, 2);
`endif

    repeat (3) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
